// File: rtl/imhotep_pkg.sv
// Shared core types for the writeback stage: datapath width, grant encoding
// and the result record carried by each writeback channel.
package imhotep_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_LSU  = 2'd2
  } wb_src_e;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, set at
// issue and cleared when the matching result is accepted. x0 is never busy.
module wb_scoreboard
  import imhotep_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             set_i,
  input  logic [4:0]       set_rd_i,
  input  logic             clr_i,
  input  logic [4:0]       clr_rd_i,
  output logic [NREGS-1:0] busy_o
);

  logic [NREGS-1:0] busy_q, busy_d;

  assign busy_d[0] = 1'b0;

  // Set is tested first so a same-cycle issue to a retiring rd stays pending.
  for (genvar n = 1; n < NREGS; n++) begin : g_bit
    always_comb begin
      busy_d[n] = busy_q[n];
      if (set_i && set_rd_i == 5'(n))
        busy_d[n] = 1'b1;
      else if (clr_i && clr_rd_i == 5'(n))
        busy_d[n] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/writeback_unit.sv
// Writeback arbiter between ALU and LSU result channels with an ALU anti-starvation
// counter, pending-write scoreboard and optional operand forwarding (WB_FORWARD_EN).
module writeback_unit
  import imhotep_pkg::*;
#(
  parameter int STARVE_MAX = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            alu_valid_i,
  input  logic [4:0]      alu_rd_i,
  input  logic [XLEN-1:0] alu_result_i,
  output logic            alu_ready_o,
  input  logic            lsu_valid_i,
  input  logic [4:0]      lsu_rd_i,
  input  logic [XLEN-1:0] lsu_data_i,
  output logic            lsu_ready_o,
  input  logic            issue_valid_i,
  input  logic [4:0]      issue_rd_i,
  output logic [31:0]     busy_o,
  output logic [4:0]      w_addr_o,
  output logic [XLEN-1:0] w_value_o,
  input  logic [4:0]      r1_addr_i,
  input  logic [4:0]      r2_addr_i,
  input  logic [XLEN-1:0] rf_r1_i,
  input  logic [XLEN-1:0] rf_r2_i,
  output logic [XLEN-1:0] r1_value_o,
  output logic [XLEN-1:0] r2_value_o
);

  localparam int            SW   = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  wb_src_e         grant;
  wb_req_t         alu_req, lsu_req, sel;
  logic [SW-1:0]   starve_q, starve_d;
  logic [4:0]      w_addr_q, w_addr_d;
  logic [XLEN-1:0] w_value_q, w_value_d;

  assign alu_req = '{rd: alu_rd_i, data: alu_result_i};
  assign lsu_req = '{rd: lsu_rd_i, data: lsu_data_i};

  // Loads win ties unless the ALU has already waited STARVE_MAX cycles.
  always_comb begin
    grant = WB_NONE;
    if (!reset_n)
      grant = WB_NONE;
    else if (alu_valid_i && lsu_valid_i)
      grant = (starve_q == SMAX) ? WB_ALU : WB_LSU;
    else if (alu_valid_i)
      grant = WB_ALU;
    else if (lsu_valid_i)
      grant = WB_LSU;
  end

  assign alu_ready_o = (grant == WB_ALU);
  assign lsu_ready_o = (grant == WB_LSU);

  always_comb begin
    sel = '0;
    case (grant)
      WB_ALU:  sel = alu_req;
      WB_LSU:  sel = lsu_req;
      default: sel = '0;
    endcase
    w_addr_d  = sel.rd;
    w_value_d = sel.data;

    starve_d = '0;
    if (alu_valid_i && grant != WB_ALU)
      starve_d = (starve_q == SMAX) ? SMAX : starve_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_q  <= '0;
      w_addr_q  <= '0;
      w_value_q <= '0;
    end else begin
      starve_q  <= starve_d;
      w_addr_q  <= w_addr_d;
      w_value_q <= w_value_d;
    end
  end

  assign w_addr_o  = w_addr_q;
  assign w_value_o = w_value_q;

  // w_addr_d is the accepted rd (0 when nothing is granted, which clears nothing).
  wb_scoreboard u_sb (
    .clk      (clk),
    .reset_n  (reset_n),
    .set_i    (issue_valid_i),
    .set_rd_i (issue_rd_i),
    .clr_i    (grant != WB_NONE),
    .clr_rd_i (w_addr_d),
    .busy_o   (busy_o)
  );

`ifdef WB_FORWARD_EN
  assign r1_value_o = (r1_addr_i == w_addr_q && w_addr_q != 5'd0) ? w_value_q : rf_r1_i;
  assign r2_value_o = (r2_addr_i == w_addr_q && w_addr_q != 5'd0) ? w_value_q : rf_r2_i;
`else
  logic unused_fwd;
  assign unused_fwd = ^{r1_addr_i, r2_addr_i};
  assign r1_value_o = rf_r1_i;
  assign r2_value_o = rf_r2_i;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: a spec-level model checked every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_writeback_unit;
  import imhotep_pkg::*;

  localparam int SMAX = 2;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            alu_valid_i, lsu_valid_i, issue_valid_i;
  logic [4:0]      alu_rd_i, lsu_rd_i, issue_rd_i, r1_addr_i, r2_addr_i;
  logic [XLEN-1:0] alu_result_i, lsu_data_i, rf_r1_i, rf_r2_i;
  logic            alu_ready_o, lsu_ready_o;
  logic [31:0]     busy_o;
  logic [4:0]      w_addr_o;
  logic [XLEN-1:0] w_value_o, r1_value_o, r2_value_o;

  writeback_unit #(.STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset_n(reset_n),
    .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_result_i(alu_result_i), .alu_ready_o(alu_ready_o),
    .lsu_valid_i(lsu_valid_i), .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i), .lsu_ready_o(lsu_ready_o),
    .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i), .busy_o(busy_o),
    .w_addr_o(w_addr_o), .w_value_o(w_value_o),
    .r1_addr_i(r1_addr_i), .r2_addr_i(r2_addr_i), .rf_r1_i(rf_r1_i), .rf_r2_i(rf_r2_i),
    .r1_value_o(r1_value_o), .r2_value_o(r2_value_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Grant code: 0 none, 1 ALU, 2 LSU.
  function automatic int pick(input logic av, input logic lv, input int st, input logic rn);
    if (!rn)      return 0;
    if (av && lv) return (st == SMAX) ? 1 : 2;
    if (av)       return 1;
    if (lv)       return 2;
    return 0;
  endfunction

  int              m_starve, m_nstarve, m_g;
  logic [31:0]     m_busy, m_nbusy;
  logic [4:0]      m_waddr, m_nwaddr;
  logic [XLEN-1:0] m_wval, m_nwval;

  always_comb begin
    m_g       = pick(alu_valid_i, lsu_valid_i, m_starve, reset_n);
    m_nbusy   = m_busy;
    m_nwaddr  = 5'd0;
    m_nwval   = '0;
    if (m_g == 1) begin m_nwaddr = alu_rd_i; m_nwval = alu_result_i; end
    if (m_g == 2) begin m_nwaddr = lsu_rd_i; m_nwval = lsu_data_i;   end
    if (m_g != 0) m_nbusy[m_nwaddr] = 1'b0;
    if (issue_valid_i && issue_rd_i != 5'd0) m_nbusy[issue_rd_i] = 1'b1;
    m_nstarve = 0;
    if (alu_valid_i && m_g != 1) m_nstarve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= '0; m_waddr <= '0; m_wval <= '0; m_starve <= 0;
    end else begin
      m_busy <= m_nbusy; m_waddr <= m_nwaddr; m_wval <= m_nwval; m_starve <= m_nstarve;
    end
  end

  function automatic logic [XLEN-1:0] fwd(input logic [4:0] a, input logic [XLEN-1:0] rf);
`ifdef WB_FORWARD_EN
    return (a == m_waddr && m_waddr != 5'd0) ? m_wval : rf;
`else
    return rf;
`endif
  endfunction

  // One compare per cycle, mid-cycle, with inputs settled.
  always @(negedge clk) begin
    chk("m_alu_ready", alu_ready_o, (m_g == 1));
    chk("m_lsu_ready", lsu_ready_o, (m_g == 2));
    chk("m_w_addr",    w_addr_o,    m_waddr);
    chk("m_w_value",   w_value_o,   m_wval);
    chk("m_busy",      busy_o,      m_busy);
    chk("m_r1",        r1_value_o,  fwd(r1_addr_i, rf_r1_i));
    chk("m_r2",        r2_value_o,  fwd(r2_addr_i, rf_r2_i));
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk); #2;
  endtask

  initial begin
    #100000;
    n_err++;
    $display("FAIL timeout: bench did not finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "timeout");
  end

  initial begin
    alu_valid_i = 0; lsu_valid_i = 0; issue_valid_i = 0;
    alu_rd_i = 0; lsu_rd_i = 0; issue_rd_i = 0; r1_addr_i = 0; r2_addr_i = 0;
    alu_result_i = 0; lsu_data_i = 0; rf_r1_i = 'h1111; rf_r2_i = 'h2222;

    // Reset: outputs cleared, readies low even with valids asserted
    repeat (2) @(posedge clk);
    #2;
    alu_valid_i = 1; lsu_valid_i = 1; #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_w_addr", w_addr_o, 0);
    chk("rst_w_value", w_value_o, 0);
    chk("rst_alu_ready", alu_ready_o, 0);
    chk("rst_lsu_ready", lsu_ready_o, 0);
    alu_valid_i = 0; lsu_valid_i = 0;
    reset_n = 1;
    cyc();
    chk("idle_w_addr", w_addr_o, 0);

    // Lone ALU result clears its busy bit
    issue_valid_i = 1; issue_rd_i = 5; cyc(); issue_valid_i = 0;
    chk("issue5_busy", busy_o, 32'h20);
    alu_valid_i = 1; alu_rd_i = 5; alu_result_i = 'h1234; #1;
    chk("alu5_ready", alu_ready_o, 1);
    cyc(); alu_valid_i = 0;
    chk("alu5_w_addr", w_addr_o, 5);
    chk("alu5_w_value", w_value_o, 'h1234);
    chk("alu5_busy", busy_o, 0);
    cyc();
    chk("nowrite_w_addr", w_addr_o, 0);
    chk("nowrite_w_value", w_value_o, 0);

    // Both valid: LSU first, ALU next cycle
    alu_valid_i = 1; alu_rd_i = 3; alu_result_i = 'h333;
    lsu_valid_i = 1; lsu_rd_i = 4; lsu_data_i = 'h444; #1;
    chk("tie_alu_ready", alu_ready_o, 0);
    chk("tie_lsu_ready", lsu_ready_o, 1);
    cyc(); lsu_valid_i = 0;
    chk("tie_w_addr_lsu", w_addr_o, 4);
    chk("tie_w_value_lsu", w_value_o, 'h444);
    #1 chk("tie2_alu_ready", alu_ready_o, 1);
    cyc(); alu_valid_i = 0;
    chk("tie_w_addr_alu", w_addr_o, 3);
    chk("tie_w_value_alu", w_value_o, 'h333);

    // Starvation: ALU forced on the third contended cycle
    alu_valid_i = 1; alu_rd_i = 10; alu_result_i = 'hA;
    lsu_valid_i = 1; lsu_rd_i = 11; lsu_data_i = 'hB;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("starve_lsu_ready", lsu_ready_o, 1);
      chk("starve_alu_ready", alu_ready_o, 0);
      cyc();
      chk("starve_w_addr_lsu", w_addr_o, 11);
    end
    #1;
    chk("starve3_alu_ready", alu_ready_o, 1);
    chk("starve3_lsu_ready", lsu_ready_o, 0);
    cyc();
    chk("starve3_w_addr", w_addr_o, 10);
    #1 chk("starve4_lsu_ready", lsu_ready_o, 1);
    cyc(); alu_valid_i = 0; lsu_valid_i = 0;
    chk("starve4_w_addr", w_addr_o, 11);
    cyc();

    // Same-edge issue and retire on rd 7; issue to x0
    issue_valid_i = 1; issue_rd_i = 7; cyc();
    chk("issue7_busy", busy_o, 32'h80);
    alu_valid_i = 1; alu_rd_i = 7; alu_result_i = 'h77; cyc();
    alu_valid_i = 0; issue_rd_i = 0;
    chk("setclr7_busy", busy_o, 32'h80);
    chk("setclr7_w_addr", w_addr_o, 7);
    cyc(); issue_valid_i = 0;
    chk("issue0_busy", busy_o, 32'h80);

    // rd=0 result still handshakes but writes nothing
    alu_valid_i = 1; alu_rd_i = 0; alu_result_i = 'hDEAD; #1;
    chk("rd0_alu_ready", alu_ready_o, 1);
    cyc(); alu_valid_i = 0;
    chk("rd0_w_addr", w_addr_o, 0);
    chk("rd0_busy", busy_o, 32'h80);

    // Operand read path
    lsu_valid_i = 1; lsu_rd_i = 9; lsu_data_i = 'hCAFE; cyc(); lsu_valid_i = 0;
    r1_addr_i = 9; rf_r1_i = 0; r2_addr_i = 9; rf_r2_i = 5; #1;
`ifdef WB_FORWARD_EN
    chk("fwd_r1", r1_value_o, 'hCAFE);
    chk("fwd_r2", r2_value_o, 'hCAFE);
`else
    chk("nofwd_r1", r1_value_o, 0);
    chk("nofwd_r2", r2_value_o, 5);
`endif
    r1_addr_i = 0; rf_r1_i = 'h55; #1;
    chk("fwd_r1_x0", r1_value_o, 'h55);
    cyc();

    // Reset mid-stream with busy bits set and a result in flight
    issue_valid_i = 1; issue_rd_i = 12;
    alu_valid_i = 1; alu_rd_i = 20; alu_result_i = 'h2020; cyc();
    issue_valid_i = 0;
    chk("pre_rst_w_addr", w_addr_o, 20);
    chk("pre_rst_busy", busy_o, 32'h1080);
    reset_n = 0; #1;
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_w_addr", w_addr_o, 0);
    chk("mid_rst_w_value", w_value_o, 0);
    chk("mid_rst_alu_ready", alu_ready_o, 0);
    alu_valid_i = 0;
    cyc(); reset_n = 1;
    cyc(); cyc();
    chk("post_rst_w_addr", w_addr_o, 0);
    chk("post_rst_busy", busy_o, 0);

    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
